decode_stage: RTL and testbench

- Registered, handshaked successor to the combinational decode step. Sits between fetch and execute.
- Decodes `instr` through the existing control and immgen sub-modules, reads the register file, and resolves operands from N forwarding sources.
- Detects load-use hazards and inserts bubbles; honours a flush from branch resolution.
- Presents a registered `Inst` plus two operand words to execute with valid/ready flow control.

---
 rtl/decode_stage_pkg.sv | 64 ++++++
 rtl/fwd_mux.sv | 25 ++
 rtl/immgen.sv | 27 ++
 rtl/single_cycle_control.sv | 70 +++++++
 rtl/decode_stage.sv | 93 +++++++++
 tb/tb_decode_stage.sv | 328 ++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: the decoded-instruction record, the control bundle,
// opcode constants and the register-index geometry used across decode.
package decode_stage_pkg;

  localparam int XLEN  = 32;
  localparam int RADDR = 6;
  localparam logic [RADDR-1:0] ZERO_REG = '0;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FLW    = 7'b0000111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_FSW    = 7'b0100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_FP     = 7'b1010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_FP
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    alu_imm;
    logic    rd_fp;
    logic    rs0_fp;
    logic    rs1_fp;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t            control;
    logic [XLEN-1:0]  imm;
    logic [RADDR-1:0] rs0;
    logic [RADDR-1:0] rs1;
    logic [RADDR-1:0] rd;
    logic [XLEN-1:0]  pc;
  } Inst;

  localparam Inst NOP_INST = '0;

  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Priority operand selector: the lowest-indexed valid source whose destination
// matches rs wins; register index 0 never forwards.
module fwd_mux #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 6
) (
  input  logic [ADDR_W-1:0]         rs,
  input  logic [DATA_W-1:0]         rf_data,
  input  logic [NUM_SRC-1:0]        fwd_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] fwd_rd,
  input  logic [NUM_SRC*DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]         data
);

  // Scanning from the oldest source down lets the youngest match overwrite last.
  always_comb begin
    data = rf_data;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_rd[i*ADDR_W +: ADDR_W] == rs && rs != '0)
        data = fwd_data[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/immgen.sv
// Immediate generator: sign-extended immediate for every RV32 encoding format.
module immgen
  import decode_stage_pkg::*;
(
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    imm = '0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_FLW:
        imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE, OP_FSW:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {instr[31:12], 12'b0};
      OP_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/single_cycle_control.sv
// Main control decoder: opcode to control bundle, including which register
// fields address the float file.
module single_cycle_control
  import decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic       alt;

  assign opcode = instr[6:0];
  // instr[30] selects SUB/SRA only where it is not part of an immediate.
  assign alt    = instr[30] && (opcode == OP_REG || instr[14:12] == 3'b101);

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    case (opcode)
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_imm   = 1'b1;
        ctrl.alu_op    = alu_decode(instr[14:12], alt);
      end
      OP_REG: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = alu_decode(instr[14:12], alt);
      end
      OP_LOAD, OP_FLW: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_imm   = 1'b1;
        ctrl.rd_fp     = (opcode == OP_FLW);
      end
      OP_STORE, OP_FSW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_imm   = 1'b1;
        ctrl.rs1_fp    = (opcode == OP_FSW);
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_JAL, OP_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.alu_imm   = (opcode == OP_JALR);
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_imm   = 1'b1;
        ctrl.alu_op    = ALU_LUI;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_imm   = 1'b1;
      end
      OP_FP: begin
        ctrl.reg_write = 1'b1;
        ctrl.rd_fp     = 1'b1;
        ctrl.rs0_fp    = 1'b1;
        ctrl.rs1_fp    = 1'b1;
        ctrl.alu_op    = ALU_FP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute: decode, register read,
// operand forwarding, load-use stall and flush, with valid/ready on both sides.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     flush,
  output logic [RADDR-1:0]         rs0,
  output logic [RADDR-1:0]         rs1,
  input  logic [XLEN-1:0]          rs0data,
  input  logic [XLEN-1:0]          rs1data,
  input  logic [NUM_FWD-1:0]       fwd_valid,
  input  logic [NUM_FWD*RADDR-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]  fwd_data,
  input  logic                     ld_pending,
  input  logic [RADDR-1:0]         ld_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output Inst                      out_inst,
  output logic [XLEN-1:0]          out_rdata0,
  output logic [XLEN-1:0]          out_rdata1,
  output logic [CNT_W-1:0]         stall_cnt
);

  ctrl_t            ctrl;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  op0;
  logic [XLEN-1:0]  op1;
  logic [RADDR-1:0] rd;
  logic             hz;
  logic             accept;
  logic             stall;

  single_cycle_control u_ctrl (.instr(in_instr), .ctrl(ctrl));
  immgen               u_imm  (.instr(in_instr), .imm(imm));

  assign rs0 = {ctrl.rs0_fp, in_instr[19:15]};
  assign rs1 = {ctrl.rs1_fp, in_instr[24:20]};
  assign rd  = {ctrl.rd_fp,  in_instr[11:7]};

  fwd_mux #(.NUM_SRC(NUM_FWD), .DATA_W(XLEN), .ADDR_W(RADDR)) u_fwd0 (
    .rs(rs0), .rf_data(rs0data), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .data(op0)
  );

  fwd_mux #(.NUM_SRC(NUM_FWD), .DATA_W(XLEN), .ADDR_W(RADDR)) u_fwd1 (
    .rs(rs1), .rf_data(rs1data), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .data(op1)
  );

  // Conservative: rs1 is compared even for opcodes that never read it.
  assign hz       = in_valid && ld_pending && (ld_rd != ZERO_REG)
                    && (ld_rd == rs0 || ld_rd == rs1);
  assign in_ready = !hz && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign stall    = in_valid && !in_ready && !flush;

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                   out_valid <= 1'b0;
    else if (accept)             out_valid <= 1'b1;
    else if (flush || out_ready) out_valid <= 1'b0;
  end

  // Payload loads only on accept, so it stays bit-stable under backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_inst   <= NOP_INST;
      out_rdata0 <= '0;
      out_rdata1 <= '0;
    end else if (accept) begin
      out_inst   <= '{control: ctrl, imm: imm, rs0: rs0, rs1: rs1, rd: rd, pc: in_pc};
      out_rdata0 <= op0;
      out_rdata1 <= op1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cnt <= '0;
    else if (stall && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected records are queued when an
// instruction is handed over and compared when execute consumes it.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk, rstn;
  logic        in_valid, in_ready, flush, ld_pending, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, rs0data, rs1data, out_rdata0, out_rdata1;
  logic [5:0]  rs0, rs1, ld_rd;
  logic [1:0]  fwd_valid;
  logic [11:0] fwd_rd;
  logic [63:0] fwd_data;
  Inst         out_inst;
  logic [31:0] stall_cnt;

  logic        sat_in_ready, sat_out_valid;
  logic [5:0]  sat_rs0, sat_rs1;
  Inst         sat_inst;
  logic [31:0] sat_rdata0, sat_rdata1;
  logic [1:0]  sat_cnt;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [5:0]  rs0;
    logic [5:0]  rs1;
    logic [5:0]  rd;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_stall = 0;

  decode_stage #(.NUM_FWD(2), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .rs0(rs0), .rs1(rs1),
    .rs0data(rs0data), .rs1data(rs1data), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .ld_pending(ld_pending), .ld_rd(ld_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_rdata0(out_rdata0), .out_rdata1(out_rdata1), .stall_cnt(stall_cnt)
  );

  decode_stage #(.NUM_FWD(2), .CNT_W(2)) sat_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .rs0(sat_rs0), .rs1(sat_rs1),
    .rs0data(rs0data), .rs1data(rs1data), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .ld_pending(ld_pending), .ld_rd(ld_rd),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_inst(sat_inst),
    .out_rdata0(sat_rdata0), .out_rdata1(sat_rdata1), .stall_cnt(sat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end

  function automatic logic [31:0] enc_r(input logic [6:0] op, input logic [4:0] rd_f,
                                        input logic [4:0] rs1_f, input logic [4:0] rs2_f);
    return {7'b0, rs2_f, rs1_f, 3'b000, rd_f, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] rd_f, input logic [4:0] rs1_f,
                                        input logic [11:0] imm12);
    return {imm12, rs1_f, 3'b000, rd_f, 7'b0010011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] imm,
                      input logic [5:0] r0, input logic [5:0] r1, input logic [5:0] rd,
                      input logic [31:0] d0, input logic [31:0] d1);
    exp_q.push_back('{pc: pc, imm: imm, rs0: r0, rs1: r1, rd: rd, d0: d0, d1: d1});
  endtask

  // Execute side: every handshake retires the oldest expected record.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_unexpected: got output pc=%h, required no output", out_inst.pc);
      end else begin
        e = exp_q.pop_front();
        n_cmp++; if (out_inst.pc !== e.pc) begin n_err++; $display("FAIL sb_pc: got %h required %h", out_inst.pc, e.pc); end
        n_cmp++; if (out_inst.imm !== e.imm) begin n_err++; $display("FAIL sb_imm: got %h required %h (pc %h)", out_inst.imm, e.imm, e.pc); end
        n_cmp++; if (out_inst.rs0 !== e.rs0) begin n_err++; $display("FAIL sb_rs0: got %0d required %0d (pc %h)", out_inst.rs0, e.rs0, e.pc); end
        n_cmp++; if (out_inst.rs1 !== e.rs1) begin n_err++; $display("FAIL sb_rs1: got %0d required %0d (pc %h)", out_inst.rs1, e.rs1, e.pc); end
        n_cmp++; if (out_inst.rd !== e.rd) begin n_err++; $display("FAIL sb_rd: got %0d required %0d (pc %h)", out_inst.rd, e.rd, e.pc); end
        n_cmp++; if (out_rdata0 !== e.d0) begin n_err++; $display("FAIL sb_rdata0: got %h required %h (pc %h)", out_rdata0, e.d0, e.pc); end
        n_cmp++; if (out_rdata1 !== e.d1) begin n_err++; $display("FAIL sb_rdata1: got %h required %h (pc %h)", out_rdata1, e.d1, e.pc); end
      end
    end
  end

  task automatic idle_inputs();
    in_valid = 0; in_pc = '0; in_instr = '0; flush = 0;
    rs0data = '0; rs1data = '0; fwd_valid = '0; fwd_rd = '0; fwd_data = '0;
    ld_pending = 0; ld_rd = '0; out_ready = 1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stall: got %0d required 0", stall_cnt); end
    n_cmp++; if (out_inst !== NOP_INST) begin n_err++; $display("FAIL reset_inst: got %h required 0", out_inst); end
    n_cmp++; if (out_rdata0 !== 32'd0 || out_rdata1 !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h/%h required 0/0", out_rdata0, out_rdata1); end
    rstn = 1'b1;
    exp_stall = 0;
    tick();
  endtask

  task automatic test_flow();
    out_ready = 1;
    rs1data   = 32'h5555;
    offer(32'h100, 32'h00500093);
    push(32'h100, 32'd5, 6'd0, 6'd5, 6'd1, 32'h0, 32'h5555);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flow_ready: got %b required 1", in_ready); end
    tick();
    in_valid = 0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flow_valid: got %b required 1", out_valid); end
    n_cmp++; if (stall_cnt !== 32'(exp_stall)) begin n_err++; $display("FAIL flow_stall: got %0d required %0d", stall_cnt, exp_stall); end
    tick();
  endtask

  task automatic test_forward();
    rs0data = 32'h1111; rs1data = 32'h2222;
    fwd_data = {32'hBBBB, 32'hAAAA};
    // both sources hold x3: youngest (source 0) must win
    fwd_valid = 2'b11; fwd_rd = {6'd3, 6'd3};
    offer(32'h104, enc_r(7'b0110011, 5'd7, 5'd3, 5'd4));
    push(32'h104, 32'd0, 6'd3, 6'd4, 6'd7, 32'hAAAA, 32'h2222);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fwd_ready: got %b required 1", in_ready); end
    tick();
    // source 0 targets x0 and rs0 is x0: register-file value is used
    fwd_rd = {6'd3, 6'd0};
    offer(32'h108, enc_r(7'b0110011, 5'd7, 5'd0, 5'd4));
    push(32'h108, 32'd0, 6'd0, 6'd4, 6'd7, 32'h1111, 32'h2222);
    tick();
    // only the older source is valid and it feeds operand 1
    fwd_valid = 2'b10; fwd_rd = {6'd4, 6'd3};
    offer(32'h10C, enc_r(7'b0110011, 5'd7, 5'd3, 5'd4));
    push(32'h10C, 32'd0, 6'd3, 6'd4, 6'd7, 32'h1111, 32'hBBBB);
    tick();
    // fadd.s f1,f0,f2: f0 (index 32) forwards, integer x2 must not alias f2
    fwd_valid = 2'b11; fwd_rd = {6'd2, 6'd32};
    offer(32'h110, enc_r(7'b1010011, 5'd1, 5'd0, 5'd2));
    push(32'h110, 32'd0, 6'd32, 6'd34, 6'd33, 32'hAAAA, 32'h2222);
    @(negedge clk);
    n_cmp++; if (rs0 !== 6'd32) begin n_err++; $display("FAIL fwd_rs0_float: got %0d required 32", rs0); end
    tick();
    in_valid = 0; fwd_valid = '0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fwd_last_valid: got %b required 1", out_valid); end
    tick();
  endtask

  task automatic test_load_use();
    rs0data = 32'h5151; rs1data = 32'h7171; out_ready = 1;
    offer(32'h200, enc_r(7'b0110011, 5'd6, 5'd5, 5'd7));
    ld_pending = 1; ld_rd = 6'd7;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL lu_rs1_hz: got in_ready %b required 0", in_ready); end
    tick(); exp_stall++;
    ld_rd = 6'd5;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL lu_rs0_hz: got in_ready %b required 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble: got out_valid %b required 0", out_valid); end
    n_cmp++; if (stall_cnt !== 32'(exp_stall)) begin n_err++; $display("FAIL lu_stall1: got %0d required %0d", stall_cnt, exp_stall); end
    tick(); exp_stall++;
    ld_pending = 0;
    push(32'h200, 32'd0, 6'd5, 6'd7, 6'd6, 32'h5151, 32'h7171);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL lu_release: got in_ready %b required 1", in_ready); end
    n_cmp++; if (stall_cnt !== 32'(exp_stall)) begin n_err++; $display("FAIL lu_stall2: got %0d required %0d", stall_cnt, exp_stall); end
    tick();
    // a pending load to x0 never stalls
    ld_pending = 1; ld_rd = 6'd0;
    offer(32'h204, 32'h00500093);
    push(32'h204, 32'd5, 6'd0, 6'd5, 6'd1, 32'h5151, 32'h7171);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL lu_x0: got in_ready %b required 1", in_ready); end
    tick();
    ld_pending = 0; in_valid = 0;
    @(negedge clk);
    tick();
  endtask

  task automatic test_backpressure();
    rs0data = 32'h3030; rs1data = 32'h4040; out_ready = 1;
    offer(32'h300, enc_r(7'b0110011, 5'd7, 5'd3, 5'd4));
    push(32'h300, 32'd0, 6'd3, 6'd4, 6'd7, 32'h3030, 32'h4040);
    tick();
    out_ready = 0;
    rs0data = 32'h5050; rs1data = 32'h6060;
    offer(32'h304, enc_i(5'd2, 5'd3, 12'hFFC));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b required 0", k, in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b required 1", k, out_valid); end
      n_cmp++; if (out_inst.pc !== 32'h300 || out_inst.rd !== 6'd7) begin n_err++; $display("FAIL bp_inst[%0d]: got pc %h rd %0d required 300/7", k, out_inst.pc, out_inst.rd); end
      n_cmp++; if (out_rdata0 !== 32'h3030 || out_rdata1 !== 32'h4040) begin n_err++; $display("FAIL bp_rdata[%0d]: got %h/%h required 3030/4040", k, out_rdata0, out_rdata1); end
      tick(); exp_stall++;
    end
    out_ready = 1;
    push(32'h304, 32'hFFFF_FFFC, 6'd3, 6'd28, 6'd2, 32'h5050, 32'h6060);
    @(negedge clk);
    n_cmp++; if (stall_cnt !== 32'(exp_stall)) begin n_err++; $display("FAIL bp_stall: got %0d required %0d", stall_cnt, exp_stall); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_resume: got %b required 1", in_ready); end
    tick();
    in_valid = 0;
    @(negedge clk);
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1;
    offer(32'h400, enc_r(7'b0110011, 5'd7, 5'd3, 5'd4));
    push(32'h400, 32'd0, 6'd3, 6'd4, 6'd7, rs0data, rs1data);
    tick();
    // flush kills a held output; the blocked wrong-path offer is not a stall
    out_ready = 0; flush = 1;
    offer(32'h404, enc_r(7'b0110011, 5'd8, 5'd3, 5'd4));
    void'(exp_q.pop_back());
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_held_ready: got %b required 0", in_ready); end
    tick();
    flush = 0; in_valid = 0; out_ready = 1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_kill: got out_valid %b required 0", out_valid); end
    n_cmp++; if (stall_cnt !== 32'(exp_stall)) begin n_err++; $display("FAIL fl_stall: got %0d required %0d", stall_cnt, exp_stall); end
    tick();
    // wrong-path instruction is handed over and dropped
    flush = 1;
    offer(32'h408, enc_r(7'b0110011, 5'd9, 5'd3, 5'd4));
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready: got %b required 1", in_ready); end
    tick();
    flush = 0; in_valid = 0;
    repeat (2) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_drop: got out_valid %b required 0", out_valid); end
      tick();
    end
    // flush together with a load-use hazard adds no stall
    flush = 1; ld_pending = 1; ld_rd = 6'd5;
    offer(32'h40C, enc_r(7'b0110011, 5'd6, 5'd5, 5'd7));
    tick();
    flush = 0; ld_pending = 0; in_valid = 0;
    @(negedge clk);
    n_cmp++; if (stall_cnt !== 32'(exp_stall) || out_valid !== 1'b0) begin n_err++; $display("FAIL fl_hz: got stall %0d valid %b required %0d/0", stall_cnt, out_valid, exp_stall); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    offer(32'h500, enc_r(7'b0110011, 5'd7, 5'd3, 5'd4));
    push(32'h500, 32'd0, 6'd3, 6'd4, 6'd7, rs0data, rs1data);
    tick();
    in_valid = 0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rm_loaded: got %b required 1", out_valid); end
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_inst !== NOP_INST) begin n_err++; $display("FAIL rm_async: got valid %b inst %h required 0/0", out_valid, out_inst); end
    n_cmp++; if (stall_cnt !== 32'd0 || sat_cnt !== 2'd0) begin n_err++; $display("FAIL rm_stall: got %0d/%0d required 0/0", stall_cnt, sat_cnt); end
    exp_q.delete();
    exp_stall = 0;
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1;
    tick();
  endtask

  task automatic test_saturation();
    ld_pending = 1; ld_rd = 6'd5;
    offer(32'h600, enc_r(7'b0110011, 5'd6, 5'd5, 5'd7));
    repeat (2) begin tick(); exp_stall++; end
    @(negedge clk);
    n_cmp++; if (sat_cnt !== 2'b10) begin n_err++; $display("FAIL sat_pre: got %b required 10", sat_cnt); end
    n_cmp++; if (stall_cnt !== 32'(exp_stall)) begin n_err++; $display("FAIL sat_main_pre: got %0d required %0d", stall_cnt, exp_stall); end
    repeat (3) begin tick(); exp_stall++; end
    @(negedge clk);
    n_cmp++; if (sat_cnt !== 2'b11) begin n_err++; $display("FAIL sat_hold: got %b required 11", sat_cnt); end
    n_cmp++; if (stall_cnt !== 32'(exp_stall)) begin n_err++; $display("FAIL sat_main: got %0d required %0d", stall_cnt, exp_stall); end
    in_valid = 0; ld_pending = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_flow();
    test_forward();
    test_load_use();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_saturation();
    repeat (2) tick();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d pending records required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
